// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle RISC-V PC owner and fetch/exec sequencer; MISALIGN_TRAP_EN enables the misaligned-target trap
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_ack,
   input  logic        instr_done,
   input  logic        stall,
   input  logic [1:0]  flag_branch,
   input  logic [31:0] pc_target,
   input  logic        branch_taken,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_req,
   output logic        redirect,
   output logic        flush,
   output logic        trap,
   output logic [31:0] trap_pc,
   output logic [31:0] retired
);
`ifdef MISALIGN_TRAP_EN
   typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
`endif
   state_t state_q, state_d;
   logic [31:0] pc_q, pc_d, retired_q, retired_d, tgt, next_pc;
   logic fetch_req_q, fetch_req_d, redirect_q, redirect_d, flush_q, flush_d, sel_tgt, advance;
`ifdef MISALIGN_TRAP_EN
   logic trap_q, trap_d;
   logic [31:0] trap_pc_q, trap_pc_d;
`endif
   assign pc_plus4 = pc_q + 32'd4;
   always_comb begin
      sel_tgt = (flag_branch == 2'b01) || (flag_branch == 2'b10) || (flag_branch == 2'b11 && branch_taken);
      tgt = flag_branch == 2'b10 ? {pc_target[31:1], 1'b0} : pc_target;
      next_pc = sel_tgt ? tgt : pc_plus4;
      advance = state_q == EXEC && instr_done && !stall;
      state_d = state_q;
      pc_d = pc_q;
      fetch_req_d = fetch_req_q;
      retired_d = retired_q;
      redirect_d = 1'b0;
      flush_d = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = FETCH;
            fetch_req_d = 1'b1;
         end
         FETCH: if (fetch_ack) begin
            state_d = EXEC;
            fetch_req_d = 1'b0;
         end
         EXEC: if (advance) begin
            state_d = FETCH;
            fetch_req_d = 1'b1;
            pc_d = next_pc;
            retired_d = retired_q + 32'd1;
            redirect_d = next_pc != pc_plus4;
            flush_d = next_pc != pc_plus4;
         end
         default: begin
            state_d = FETCH;
            fetch_req_d = 1'b1;
         end
      endcase
`ifdef MISALIGN_TRAP_EN
      trap_d = 1'b0;
      trap_pc_d = trap_pc_q;
      // a misaligned jump never retires; PC is vectored on TRAP entry so it is visible with the trap pulse
      if (advance && sel_tgt && tgt[1:0] != 2'b00) begin
         state_d = TRAP;
         fetch_req_d = 1'b0;
         pc_d = TRAP_VEC;
         retired_d = retired_q;
         redirect_d = 1'b0;
         flush_d = 1'b1;
         trap_d = 1'b1;
         trap_pc_d = pc_q;
      end
`endif
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q <= RESET_VEC;
         fetch_req_q <= 1'b0;
         redirect_q <= 1'b0;
         flush_q <= 1'b0;
         retired_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q <= pc_d;
         fetch_req_q <= fetch_req_d;
         redirect_q <= redirect_d;
         flush_q <= flush_d;
         retired_q <= retired_d;
      end
   end
`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         trap_q <= 1'b0;
         trap_pc_q <= 32'd0;
      end else begin
         trap_q <= trap_d;
         trap_pc_q <= trap_pc_d;
      end
   end
   assign trap = trap_q;
   assign trap_pc = trap_pc_q;
`else
   assign trap = 1'b0;
   assign trap_pc = 32'd0;
`endif
   assign pc = pc_q;
   assign fetch_req = fetch_req_q;
   assign redirect = redirect_q;
   assign flush = flush_q;
   assign retired = retired_q;
endmodule
